riscv_mem_responder: RTL

Memory-side responder for the RISC-V core's instruction and data cache ports. It is a single-ported word SRAM shared by the icache and dcache request streams. It arbitrates between them, performs byte-enabled writes, and returns registered read data. It drives the core's `stall` input whenever a request cannot complete in one cycle. It sits directly under the core in the top-level and closes the `icache_*`/`dcache_*`/`stall` protocol.

---
 rtl/riscv_mem_responder_if.sv | 23 ++
 rtl/riscv_mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/riscv_mem_responder_if.sv
// Core <-> memory responder bus: icache read port, dcache read/write port, shared stall and err.
interface riscv_mem_responder_if;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic [31:0] dcache_addr;
    logic [3:0]  dcache_we;
    logic        dcache_re;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        err;

    modport master (
        output icache_addr, icache_re, dcache_addr, dcache_we, dcache_re, dcache_din,
        input  icache_dout, dcache_dout, stall, err
    );

    modport slave (
        input  icache_addr, icache_re, dcache_addr, dcache_we, dcache_re, dcache_din,
        output icache_dout, dcache_dout, stall, err
    );
endinterface

// File: rtl/riscv_mem_responder.sv
// Single-ported word SRAM shared by icache/dcache, D served first, optional wait states.
// Define RISCV_MEM_BOUNDS_CHECK_EN to zero out-of-range reads, drop out-of-range writes and pulse err.
module riscv_mem_responder #(
    parameter int unsigned ADDR_BITS   = 14,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic                  clk,
    input logic                  reset,
    riscv_mem_responder_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CONFLICT} state_t;

    logic [31:0] mem [DEPTH];

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               accept, complete, do_d, do_i, do_pend_i;

    logic               req_i_re, req_d_re;
    logic [3:0]         req_d_we;
    logic [31:0]        req_i_addr, req_d_addr, req_din;

    logic               sel_i_re, sel_d_re, sel_d_acc;
    logic [3:0]         sel_d_we;
    logic [31:0]        sel_i_addr, sel_d_addr, sel_din;
    logic [ADDR_BITS-1:0] d_idx, i_idx, p_idx;
    logic               d_oob, i_oob, p_oob;

    // In IDLE the live inputs complete directly; later the latched request is used
    assign sel_i_re   = (state == S_IDLE) ? bus.icache_re   : req_i_re;
    assign sel_i_addr = (state == S_IDLE) ? bus.icache_addr : req_i_addr;
    assign sel_d_re   = (state == S_IDLE) ? bus.dcache_re   : req_d_re;
    assign sel_d_we   = (state == S_IDLE) ? bus.dcache_we   : req_d_we;
    assign sel_d_addr = (state == S_IDLE) ? bus.dcache_addr : req_d_addr;
    assign sel_din    = (state == S_IDLE) ? bus.dcache_din  : req_din;
    assign sel_d_acc  = sel_d_re | (|sel_d_we);

    assign d_idx = sel_d_addr[ADDR_BITS+1:2];
    assign i_idx = sel_i_addr[ADDR_BITS+1:2];
    assign p_idx = req_i_addr[ADDR_BITS+1:2];

`ifdef RISCV_MEM_BOUNDS_CHECK_EN
    assign d_oob = |sel_d_addr[31:ADDR_BITS+2];
    assign i_oob = |sel_i_addr[31:ADDR_BITS+2];
    assign p_oob = |req_i_addr[31:ADDR_BITS+2];
    logic unused_bits;
    assign unused_bits = &{1'b0, sel_d_addr[1:0], sel_i_addr[1:0], req_i_addr[1:0]};
`else
    assign d_oob = 1'b0;
    assign i_oob = 1'b0;
    assign p_oob = 1'b0;
    logic unused_bits;
    assign unused_bits = &{1'b0, sel_d_addr[31:ADDR_BITS+2], sel_d_addr[1:0],
                           sel_i_addr[31:ADDR_BITS+2], sel_i_addr[1:0],
                           req_i_addr[31:ADDR_BITS+2], req_i_addr[1:0]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_i_re   <= 1'b0;
            req_d_re   <= 1'b0;
            req_d_we   <= 4'h0;
            req_i_addr <= '0;
            req_d_addr <= '0;
            req_din    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_i_re   <= bus.icache_re;
                req_d_re   <= bus.dcache_re;
                req_d_we   <= bus.dcache_we;
                req_i_addr <= bus.icache_addr;
                req_d_addr <= bus.dcache_addr;
                req_din    <= bus.dcache_din;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        complete  = 1'b0;
        do_d      = 1'b0;
        do_i      = 1'b0;
        do_pend_i = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.icache_re | bus.dcache_re | (|bus.dcache_we)) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) complete = 1'b1;
            end
            S_CONFLICT: begin
                do_pend_i = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // D always wins; a concurrent I read is deferred one cycle so it sees the write
        if (complete) begin
            do_d      = sel_d_acc;
            do_i      = sel_i_re & ~sel_d_acc;
            state_nxt = (sel_d_acc & sel_i_re) ? S_CONFLICT : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_d && !d_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_d_we[b]) mem[d_idx][8*b +: 8] <= sel_din[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.icache_dout <= '0;
            bus.dcache_dout <= '0;
            bus.stall       <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.stall <= (state_nxt != S_IDLE);
            bus.err   <= (do_d & d_oob) | (do_i & i_oob) | (do_pend_i & p_oob);
            if (do_d && sel_d_re) bus.dcache_dout <= d_oob ? 32'h0 : mem[d_idx];
            if (do_i)             bus.icache_dout <= i_oob ? 32'h0 : mem[i_idx];
            else if (do_pend_i)   bus.icache_dout <= p_oob ? 32'h0 : mem[p_idx];
        end
    end

endmodule
